// File: rtl/digit_sprite_renderer.sv
// Digit sprite renderer: maps the VGA scan position onto digit-ROM row/column
// requests, hides the ROM's one-cycle read latency and produces the final
// 12-bit pixel colour. Sprite position and digit are double-buffered
// (shadow -> committed) and committed only at frame start, so a moving or
// changing digit never tears mid-frame.
//
// Optional feature: define DIGIT_SCALE2X_EN to draw the sprite at 2x scale
// (each ROM texel covers 2x2 pixels). Latency is unchanged.
//
// Ports:
//   clk, reset_n        pixel clock, async active-low reset
//   frame_start         one-cycle pulse at the start of each frame
//   pixel_x/y, video_on scan position and visible-area flag
//   upd_valid/x/y/digit shadow register load
//   bg_color            colour where the sprite is absent or transparent
//   rom_digit           committed digit, selects the digit ROM
//   rom_row/rom_col     ROM address request
//   rom_color           ROM data, valid one clk after the address
//   rgb, rgb_valid      final colour and video_on aligned to it (3-clk latency)
//   upd_pending         shadow holds an uncommitted update
module digit_sprite_renderer #(
   parameter int unsigned SPR_W      = 25,
   parameter int unsigned SPR_H      = 30,
   parameter int unsigned NUM_DIGITS = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        upd_valid,
   input  logic [9:0]  upd_x,
   input  logic [9:0]  upd_y,
   input  logic [3:0]  upd_digit,
   input  logic [11:0] bg_color,
   output logic [3:0]  rom_digit,
   output logic [4:0]  rom_row,
   output logic [4:0]  rom_col,
   input  logic [11:0] rom_color,
   output logic [11:0] rgb,
   output logic        rgb_valid,
   output logic        upd_pending
);

`ifdef DIGIT_SCALE2X_EN
   localparam int unsigned SCALE = 2;
`else
   localparam int unsigned SCALE = 1;
`endif

   localparam int unsigned POS_W  = 10;
   localparam int unsigned DIFF_W = POS_W + 1;
   localparam logic [DIFF_W-1:0] FOOT_W    = DIFF_W'(SPR_W * SCALE);
   localparam logic [DIFF_W-1:0] FOOT_H    = DIFF_W'(SPR_H * SCALE);
   localparam logic [4:0]        DIGIT_LIM = 5'(NUM_DIGITS);

   typedef struct packed {
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
      logic [3:0]       digit;
   } sprite_t;

   sprite_t shadow;
   sprite_t committed;

   logic              commit_c;
   logic [DIFF_W-1:0] dx_c;
   logic [DIFF_W-1:0] dy_c;
   logic              hit_c;
   logic [4:0]        row_c;
   logic [4:0]        col_c;

   logic hit_d1, von_d1;
   logic hit_d2, von_d2;

   assign commit_c  = frame_start & upd_pending;
   assign rom_digit = committed.digit;

   // Shadow/committed double buffer; commit uses the shadow value from before this edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow      <= '0;
         committed   <= '0;
         upd_pending <= 1'b0;
      end else begin
         if (commit_c) begin
            committed <= shadow;
         end
         if (upd_valid) begin
            shadow      <= '{x: upd_x, y: upd_y, digit: upd_digit};
            upd_pending <= 1'b1;
         end else if (commit_c) begin
            upd_pending <= 1'b0;
         end
      end
   end

   // Hit test in 11 bits so a sprite hanging past column/row 1023 is clipped, not wrapped
   always_comb begin
      dx_c  = {1'b0, pixel_x} - {1'b0, committed.x};
      dy_c  = {1'b0, pixel_y} - {1'b0, committed.y};
      hit_c = (pixel_x >= committed.x) && (dx_c < FOOT_W) &&
              (pixel_y >= committed.y) && (dy_c < FOOT_H) &&
              ({1'b0, committed.digit} < DIGIT_LIM);
      row_c = '0;
      col_c = '0;
      if (hit_c) begin
`ifdef DIGIT_SCALE2X_EN
         row_c = dy_c[5:1];
         col_c = dx_c[5:1];
`else
         row_c = dy_c[4:0];
         col_c = dx_c[4:0];
`endif
      end
   end

   // Stage 1: ROM address plus hit/video flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rom_row <= '0;
         rom_col <= '0;
         hit_d1  <= 1'b0;
         von_d1  <= 1'b0;
      end else begin
         rom_row <= row_c;
         rom_col <= col_c;
         hit_d1  <= hit_c;
         von_d1  <= video_on;
      end
   end

   // Stage 2: flags aligned with the ROM's registered read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_d2 <= 1'b0;
         von_d2 <= 1'b0;
      end else begin
         hit_d2 <= hit_d1;
         von_d2 <= von_d1;
      end
   end

   // Stage 3: colour select; ROM colour 12'h000 is transparent
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb       <= '0;
         rgb_valid <= 1'b0;
      end else begin
         rgb_valid <= von_d2;
         if (!von_d2) begin
            rgb <= '0;
         end else if (hit_d2 && (rom_color != 12'h000)) begin
            rgb <= rom_color;
         end else begin
            rgb <= bg_color;
         end
      end
   end

endmodule

// File: doc/digit_sprite_renderer.md
Name: digit_sprite_renderer

Overview:
- Consumer side of the digit sprite ROMs: converts the VGA scan position into ROM row/col requests, absorbs the ROM's 1-cycle registered read latency, and produces the final 12-bit pixel colour.
- Sits between the VGA timing generator and the RGB output mux.
- Sprite position and digit are double-buffered and committed only at frame start, so a moving or changing digit never tears mid-frame.

Parameters:
- SPR_W, 25, sprite width in ROM columns
- SPR_H, 30, sprite height in ROM rows
- NUM_DIGITS, 10, valid digit codes 0..NUM_DIGITS-1

Ports:
- clk  input  1  system/pixel clock; all logic on posedge
- reset_n  input  1  asynchronous active-low reset
- frame_start  input  1  single-cycle pulse at start of each frame, from timing generator
- pixel_x  input  10  current scan column
- pixel_y  input  10  current scan row
- video_on  input  1  high in the visible area
- upd_valid  input  1  load shadow position/digit registers this cycle
- upd_x  input  10  new sprite left edge
- upd_y  input  10  new sprite top edge
- upd_digit  input  4  new digit code
- bg_color  input  12  colour drawn where the sprite is absent or transparent
- rom_digit  output  4  committed digit; selects which digit ROM drives rom_color
- rom_row  output  5  ROM row request
- rom_col  output  5  ROM column request
- rom_color  input  12  ROM data, valid one clk after rom_row/rom_col
- rgb  output  12  final pixel colour
- rgb_valid  input/output alignment flag: output  1  video_on delayed to match rgb
- upd_pending  output  1  shadow holds an uncommitted update

Behaviour:
- Reset (async assert, sync release): all outputs and registers are 0. This includes shadow and committed pos_x, pos_y and digit, upd_pending, and all pipeline registers.
- Shadow load: on upd_valid, shadow_x/y/digit take upd_x/y/digit and upd_pending becomes 1. A later upd_valid before commit overwrites the shadow (last write wins).
- Commit: on frame_start with upd_pending=1, the committed regs take the shadow values and upd_pending clears.
  - frame_start with upd_pending=0: no change.
  - upd_valid and frame_start in the same cycle: frame_start commits the shadow contents from before this edge. The new upd values load into the shadow and upd_pending stays 1 for the next frame.
- rom_digit always equals the committed digit register.
- Stage 1 (edge after inputs), hit test:
  - dx = pixel_x - pos_x and dy = pixel_y - pos_y, computed in 11-bit unsigned.
  - hit = (pixel_x >= pos_x) && (dx < SPR_W) && (pixel_y >= pos_y) && (dy < SPR_H) && (digit < NUM_DIGITS).
  - Comparisons are 11-bit, so a sprite extending past 1023 is clipped with no wrap-around.
  - When hit=1, rom_row = dy[4:0] and rom_col = dx[4:0]; when hit=0 both are 0.
  - hit_d1 and von_d1 are registered alongside the address.
- Stage 2: ROM returns rom_color. hit_d2 and von_d2 are registered to align with it.
- Stage 3, output register:
  - rgb = 0 when von_d2 = 0.
  - Otherwise rgb = rom_color when hit_d2=1 and rom_color != 12'h000; otherwise rgb = bg_color.
  - rgb_valid = von_d2.
- Latency: rgb/rgb_valid for a pixel appear exactly 3 clk edges after that pixel's pixel_x/pixel_y/video_on are presented. Throughput is 1 pixel/clk with no stalls.
- Digit codes >= NUM_DIGITS draw only background.
- bg_color is sampled at stage 3 with no delay; it is a quasi-static input.
- Reset mid-frame: pipeline flushes to 0, so rgb = 0 and rgb_valid = 0 until 3 cycles after release. Committed position returns to (0,0), digit 0.

Optional Feature:
- Macro: DIGIT_SCALE2X_EN
- Defined: footprint is 2*SPR_W x 2*SPR_H (50x60). The hit test uses dx < 2*SPR_W and dy < 2*SPR_H; rom_row = dy[5:1] and rom_col = dx[5:1], so each ROM texel covers 2x2 pixels. Latency is unchanged.
- Undefined: 1:1 mapping as specified above.

Test Plan:
- Reset then idle scan with video_on=1, bg_color=12'h00F → rgb=12'h00F and rgb_valid=1 three cycles after video_on, rom_row/rom_col=0.
- upd x=100, y=50, digit=7, then frame_start → upd_pending goes 1 then 0. Pixel (100,50) gives rom_row=0, rom_col=0 one cycle later, and rgb equals the ROM colour (12'hFFF) 3 cycles after the pixel. Pixel (124,79) gives row=29, col=24; pixel (125,50) gives rgb=bg_color.
- upd_valid mid-frame with x=200 → drawing stays at x=100 until the next frame_start; upd_pending=1 throughout.
- upd_valid and frame_start in the same cycle, with shadow x=300 pending and new x=400 → committed x=300, shadow x=400, upd_pending=1.
- pos_x=1010, scan pixel_x 1010..1023 → hit for those columns only, no wrap to column 0. digit=12 → rgb=bg_color everywhere.
- Assert reset_n=0 during the sprite region → rgb=0 and rgb_valid=0 immediately, and for 3 cycles after release. With DIGIT_SCALE2X_EN, pixel (101,51) → row=0, col=0 and pixel (149,109) → row=29, col=24.
